// File: rtl/fetch_queue.sv
// Instruction prefetch queue: in-order fetch requests, response queue, redirect flush with stale-response drop.
// Optional FETCHQ_STATS_EN adds a saturating redirect counter output RedirectCnt_IF.
module fetch_queue #(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall_ID,
  input  logic              Jump_IDM1,
  input  logic [25:0]       JumpTgt_IDM1,
  input  logic              BranchTaken_EXM1,
  input  logic [31:0]       RedirectPc_EXM1,
  output logic              ImemReq,
  output logic [31:0]       ImemAddr,
  input  logic              ImemGnt,
  input  logic              ImemRspVal,
  input  logic [DATA_W-1:0] ImemRspData,
  output logic              InstrVal_IF,
  output logic [31:0]       Pc_IF,
  output logic [DATA_W-1:0] FetchData_IF
`ifdef FETCHQ_STATS_EN
  ,
  output logic [15:0]       RedirectCnt_IF
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  logic [31:0]       r_fpc;
  logic [31:0]       r_rsp_pc;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_outst;
  logic [CNT_W-1:0]  r_drop;
  logic [31:0]       r_pc_q   [DEPTH];
  logic [DATA_W-1:0] r_data_q [DEPTH];

  logic              w_redirect;
  logic [31:0]       w_tgt;
  logic              w_room;
  logic              w_acc;
  logic              w_enq;
  logic              w_deq;
  logic              w_drop_rsp;
  logic [CNT_W-1:0]  w_outst_dec;

  assign w_redirect = BranchTaken_EXM1 | Jump_IDM1;
  assign w_tgt      = BranchTaken_EXM1 ? RedirectPc_EXM1
                                       : {r_fpc[31:28], JumpTgt_IDM1, 2'b00};
  // Stale responses still hold a slot until they return, so they count against room.
  assign w_room     = ({1'b0, r_occ} + {1'b0, r_outst}) < DEPTH_L;
  assign ImemReq    = rst_n & w_room & ~w_redirect;
  assign ImemAddr   = r_fpc;
  assign w_acc      = ImemReq & ImemGnt;

  assign InstrVal_IF  = (r_occ != '0);
  assign Pc_IF        = InstrVal_IF ? r_pc_q[r_rptr]   : '0;
  assign FetchData_IF = InstrVal_IF ? r_data_q[r_rptr] : '0;

  assign w_drop_rsp  = ImemRspVal & (r_drop != '0) & ~w_redirect;
  assign w_enq       = ImemRspVal & (r_drop == '0) & ~w_redirect;
  assign w_deq       = InstrVal_IF & ~Stall_ID & ~w_redirect;
  assign w_outst_dec = (ImemRspVal && r_outst != '0) ? r_outst - CNT_W'(1) : r_outst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc    <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_occ    <= '0;
      r_outst  <= '0;
      r_drop   <= '0;
    end else if (w_redirect) begin
      // Every request still in flight after this edge belongs to the old path.
      r_fpc    <= w_tgt;
      r_rsp_pc <= w_tgt;
      r_rptr   <= r_wptr;
      r_occ    <= '0;
      r_outst  <= w_outst_dec;
      r_drop   <= w_outst_dec;
    end else begin
      if (w_acc) r_fpc <= r_fpc + 32'd4;
      if (w_enq) begin
        r_wptr   <= r_wptr + PTR_W'(1);
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
      r_occ   <= r_occ + CNT_W'(w_enq) - CNT_W'(w_deq);
      r_outst <= w_outst_dec + CNT_W'(w_acc);
      if (w_drop_rsp) r_drop <= r_drop - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_q[r_wptr]   <= r_rsp_pc;
      r_data_q[r_wptr] <= ImemRspData;
    end
  end

`ifdef FETCHQ_STATS_EN
  logic [15:0] r_redir_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redir_cnt <= '0;
    end else if (w_redirect && r_redir_cnt != 16'hFFFF) begin
      r_redir_cnt <= r_redir_cnt + 16'd1;
    end
  end

  assign RedirectCnt_IF = r_redir_cnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency instruction memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Stall_ID = 1'b0;
  logic        Jump_IDM1 = 1'b0;
  logic [25:0] JumpTgt_IDM1 = '0;
  logic        BranchTaken_EXM1 = 1'b0;
  logic [31:0] RedirectPc_EXM1 = '0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt = 1'b1;
  logic        ImemRspVal = 1'b0;
  logic [31:0] ImemRspData = '0;
  logic        InstrVal_IF;
  logic [31:0] Pc_IF;
  logic [31:0] FetchData_IF;
`ifdef FETCHQ_STATS_EN
  logic [15:0] RedirectCnt_IF;
`endif

  fetch_queue #(.DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .Stall_ID         (Stall_ID),
    .Jump_IDM1        (Jump_IDM1),
    .JumpTgt_IDM1     (JumpTgt_IDM1),
    .BranchTaken_EXM1 (BranchTaken_EXM1),
    .RedirectPc_EXM1  (RedirectPc_EXM1),
    .ImemReq          (ImemReq),
    .ImemAddr         (ImemAddr),
    .ImemGnt          (ImemGnt),
    .ImemRspVal       (ImemRspVal),
    .ImemRspData      (ImemRspData),
    .InstrVal_IF      (InstrVal_IF),
    .Pc_IF            (Pc_IF),
    .FetchData_IF     (FetchData_IF)
`ifdef FETCHQ_STATS_EN
    ,
    .RedirectCnt_IF   (RedirectCnt_IF)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] pq_addr [$];
  int          pq_due  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample the request/response handshake, advance, then present the next response.
  task automatic tick();
    logic        acc;
    logic        rsp;
    logic [31:0] a;
    #1;
    acc = ImemReq && ImemGnt;
    rsp = ImemRspVal;
    a   = ImemAddr;
    @(posedge clk);
    #1;
    cyc++;
    if (rsp && pq_addr.size() > 0) begin
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end
    if (acc) begin
      pq_addr.push_back(a);
      pq_due.push_back(cyc + lat - 1);
    end
    if (pq_addr.size() > 0 && pq_due[0] <= cyc) begin
      ImemRspVal  = 1'b1;
      ImemRspData = mem_word(pq_addr[0]);
    end else begin
      ImemRspVal  = 1'b0;
      ImemRspData = '0;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!InstrVal_IF && n < 20) begin
      tick();
      n++;
    end
    if (!InstrVal_IF) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_val"},  {31'd0, InstrVal_IF}, 32'd0);
    chk({tag, "_pc"},   Pc_IF, 32'd0);
    chk({tag, "_data"}, FetchData_IF, 32'd0);
    chk({tag, "_req"},  {31'd0, ImemReq}, 32'd0);
  endtask

  task automatic do_reset(input int new_lat);
    rst_n = 1'b0;
    Stall_ID = 1'b0;
    Jump_IDM1 = 1'b0;
    BranchTaken_EXM1 = 1'b0;
    ImemGnt = 1'b1;
    ImemRspVal = 1'b0;
    pq_addr.delete();
    pq_due.delete();
    #1;
    check_reset_outputs("rst");
`ifdef FETCHQ_STATS_EN
    chk("rst_cnt", {16'd0, RedirectCnt_IF}, 32'd0);
`endif
    tick();
    tick();
    lat = new_lat;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // Streaming at latency 1: one instruction per cycle from cycle 3.
    do_reset(1);
    tick();
    chk("s_v_c2", {31'd0, InstrVal_IF}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("s_pc%0d", i), Pc_IF, 32'(i * 4));
      chk($sformatf("s_v%0d", i), {31'd0, InstrVal_IF}, 32'd1);
    end
    chk("s_data5", FetchData_IF, mem_word(32'h14));
    ImemGnt = 1'b0;
    tick();
    tick();
    chk("nogrant_addr", ImemAddr, 32'h1C);
    chk("nogrant_req", {31'd0, ImemReq}, 32'd1);
    ImemGnt = 1'b1;

    // Decode stall fills the queue, then drains in order.
    do_reset(1);
    Stall_ID = 1'b1;
    repeat (5) tick();
    chk("full_req5", {31'd0, ImemReq}, 32'd0);
    repeat (5) tick();
    chk("full_req10", {31'd0, ImemReq}, 32'd0);
    chk("full_pc", Pc_IF, 32'h0);
    chk("full_val", {31'd0, InstrVal_IF}, 32'd1);
    chk("full_data", FetchData_IF, mem_word(32'h0));
    Stall_ID = 1'b0;
    tick();
    chk("drain_pc4", Pc_IF, 32'h4);
    tick();
    chk("drain_pc8", Pc_IF, 32'h8);
    tick();
    chk("drain_pcC", Pc_IF, 32'hC);
    tick();
    chk("drain_pc10", Pc_IF, 32'h10);

    // Branch redirect with three requests in flight at latency 3.
    do_reset(3);
    repeat (3) tick();
    BranchTaken_EXM1 = 1'b1;
    RedirectPc_EXM1 = 32'h100;
    #1;
    chk("br_req", {31'd0, ImemReq}, 32'd0);
    tick();
    BranchTaken_EXM1 = 1'b0;
    chk("br_val_after", {31'd0, InstrVal_IF}, 32'd0);
    #1;
    chk("br_addr", ImemAddr, 32'h100);
    wait_valid("br");
    chk("br_pc", Pc_IF, 32'h100);
    chk("br_data", FetchData_IF, mem_word(32'h100));
    tick();
    chk("br_pc2", Pc_IF, 32'h104);

    // Branch beats a simultaneous jump; then a lone jump.
    do_reset(1);
    repeat (4) tick();
    Jump_IDM1 = 1'b1;
    JumpTgt_IDM1 = 26'h40;
    BranchTaken_EXM1 = 1'b1;
    RedirectPc_EXM1 = 32'h200;
    #1;
    chk("both_req", {31'd0, ImemReq}, 32'd0);
    tick();
    Jump_IDM1 = 1'b0;
    BranchTaken_EXM1 = 1'b0;
    chk("both_val_after", {31'd0, InstrVal_IF}, 32'd0);
`ifdef FETCHQ_STATS_EN
    chk("both_cnt", {16'd0, RedirectCnt_IF}, 32'd1);
`endif
    wait_valid("both");
    chk("both_pc", Pc_IF, 32'h200);
    Jump_IDM1 = 1'b1;
    tick();
    Jump_IDM1 = 1'b0;
    wait_valid("jmp");
    chk("jmp_pc", Pc_IF, 32'h100);
`ifdef FETCHQ_STATS_EN
    chk("jmp_cnt", {16'd0, RedirectCnt_IF}, 32'd2);
`endif

    // Reset mid-stream with two requests in flight.
    do_reset(3);
    Stall_ID = 1'b1;
    repeat (5) tick();
    chk("mid_val", {31'd0, InstrVal_IF}, 32'd1);
    chk("mid_pc", Pc_IF, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (4) tick();
    Stall_ID = 1'b0;
    lat = 1;
    rst_n = 1'b1;
    cyc = 0;
    tick();
    chk("post_v1", {31'd0, InstrVal_IF}, 32'd0);
    tick();
    chk("post_val", {31'd0, InstrVal_IF}, 32'd1);
    chk("post_pc", Pc_IF, 32'h0);
    chk("post_data", FetchData_IF, mem_word(32'h0));
    tick();
    chk("post_pc4", Pc_IF, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
